// File: rtl/sum_serializer.sv
// sum_serializer: buffers adder sums in a small FIFO and
// shifts each word out LSB-first with a frame marker.
module sum_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   vdd,
  input  logic                   vss,
  input  logic [WIDTH-1:0]       sum_i,
  input  logic                   sum_valid_i,
  output logic                   sum_ready_o,
  input  logic                   ser_en_i,
  input  logic                   clr_ovf_i,
  output logic                   ser_data_o,
  output logic                   ser_frame_o,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shr_w;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    cnt_q;
  logic             frame_q, data_q;
  logic             full, push, pop, drop;
  logic             unused_pwr;

  assign unused_pwr = vdd ^ vss;

  assign full = (level_q == FULL);
  assign push = sum_valid_i & ~full;
  assign drop = sum_valid_i & full;
  assign pop  = (state_q == LOAD);
  assign head = mem_q[rptr_q];
  assign shr_w = shreg_q >> 1;

  // Next-state for pointers, occupancy and sticky overflow
  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (clr_ovf_i)
      ovf_d = 1'b0;
  end

  // FIFO storage; stale entries are harmless after reset
  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem_q[wptr_q] <= sum_i;
  end

  // FIFO control registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Serializer FSM with registered pin outputs
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (level_q != '0)
            state_q <= LOAD;
        end
        LOAD: begin
          shreg_q <= head;
          cnt_q   <= '0;
          frame_q <= 1'b1;
          data_q  <= head[0];
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (ser_en_i) begin
            shreg_q <= shr_w;
            if (cnt_q == LAST) begin
              frame_q <= 1'b0;
              data_q  <= 1'b0;
              state_q <= GAP;
            end else begin
              cnt_q  <= cnt_q + CW'(1);
              data_q <= shr_w[0];
            end
          end
        end
        GAP: begin
          state_q <= (level_q != '0) ? LOAD : IDLE;
        end
        default: begin
          frame_q <= 1'b0;
          data_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sum_ready_o = ~full;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;
  assign ser_frame_o = frame_q;
  assign ser_data_o  = data_q;

endmodule

// File: tb/tb_sum_serializer.sv
// tb_sum_serializer: scoreboard bench for sum_serializer.
// Frames are reassembled by a monitor and popped against expectations.
module tb_sum_serializer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vdd = 1'b1;
  logic         vss = 1'b0;
  logic [W-1:0] sum = '0;
  logic         vld = 1'b0;
  logic         en = 1'b1;
  logic         clr = 1'b0;
  logic         rdy, sdat, sfr, ovf;
  logic [$clog2(D):0] lvl;

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];
  int           gaps[$];
  int           lens[$];
  int           frames = 0;
  logic         in_fr = 1'b0;
  int           flen = 0;
  int           nb = 0;
  int           lowrun = 0;
  logic [W-1:0] word = '0;
  logic [W-1:0] exp_w;

  always #5 clk = ~clk;

  sum_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .vdd         (vdd),
    .vss         (vss),
    .sum_i       (sum),
    .sum_valid_i (vld),
    .sum_ready_o (rdy),
    .ser_en_i    (en),
    .clr_ovf_i   (clr),
    .ser_data_o  (sdat),
    .ser_frame_o (sfr),
    .overflow_o  (ovf),
    .level_o     (lvl)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame monitor: one bit captured per cycle that ser_en is high
  always @(negedge clk) begin
    if (!rst_n) begin
      in_fr = 1'b0;
      lowrun = 0;
    end else if (sfr) begin
      if (!in_fr) begin
        in_fr = 1'b1;
        flen = 0;
        nb = 0;
        word = '0;
        gaps.push_back(lowrun);
      end
      flen++;
      if (en && nb < W) begin
        word = {sdat, word[W-1:1]};
        nb++;
      end
      lowrun = 0;
    end else begin
      total++;
      if (sdat !== 1'b0) begin
        bad++;
        $display("FAIL idle_data got=%b want=0", sdat);
      end
      if (in_fr) begin
        in_fr = 1'b0;
        frames++;
        lens.push_back(flen);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%h want=none", word);
        end else begin
          exp_w = exp_q.pop_front();
          if (word !== exp_w) begin
            bad++;
            $display("FAIL sb_word got=%h want=%h", word, exp_w);
          end
        end
        total++;
        if (nb != W) begin
          bad++;
          $display("FAIL sb_bits got=%0d want=%0d", nb, W);
        end
      end
      lowrun++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (sfr !== 1'b0) begin
      bad++; $display("FAIL rst_frame got=%b want=0", sfr);
    end
    total++;
    if (sdat !== 1'b0) begin
      bad++; $display("FAIL rst_data got=%b want=0", sdat);
    end
    total++;
    if (lvl !== '0) begin
      bad++; $display("FAIL rst_level got=%0d want=0", lvl);
    end
    total++;
    if (rdy !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b want=1", rdy);
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL rst_ovf got=%b want=0", ovf);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int f0;
    f0 = frames;
    sum = 8'hA5;
    vld = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    vld = 1'b0;
    total++;
    if (lvl !== 3'd1) begin
      bad++; $display("FAIL single_lvl1 got=%0d want=1", lvl);
    end
    tick();
    total++;
    if (sfr !== 1'b0) begin
      bad++; $display("FAIL single_load got=%b want=0", sfr);
    end
    tick();
    total++;
    if (sfr !== 1'b1 || sdat !== 1'b1) begin
      bad++;
      $display("FAIL single_bit0 got=%b%b want=11", sfr, sdat);
    end
    total++;
    if (lvl !== '0) begin
      bad++; $display("FAIL single_lvl0 got=%0d want=0", lvl);
    end
    for (int i = 0; i < 40 && frames < f0 + 1; i++) tick();
    total++;
    if (frames != f0 + 1) begin
      bad++; $display("FAIL single_frames got=%0d want=1", frames - f0);
    end
    total++;
    if (lens.size() == 0 || lens[lens.size()-1] != W) begin
      bad++; $display("FAIL single_len got=%0d want=%0d",
                      (lens.size() == 0) ? -1 : lens[lens.size()-1], W);
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL single_ovf got=%b want=0", ovf);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int f0;
    int g0;
    logic [W-1:0] w [4];
    w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'hFF; w[3] = 8'h00;
    f0 = frames;
    g0 = gaps.size();
    for (int k = 0; k < 4; k++) begin
      sum = w[k];
      vld = 1'b1;
      exp_q.push_back(w[k]);
      tick();
    end
    vld = 1'b0;
    for (int i = 0; i < 80 && frames < f0 + 4; i++) tick();
    total++;
    if (frames != f0 + 4) begin
      bad++; $display("FAIL b2b_frames got=%0d want=4", frames - f0);
    end
    for (int k = 1; k < 4; k++) begin
      total++;
      if (gaps.size() <= g0 + k || gaps[g0+k] != 2) begin
        bad++;
        $display("FAIL b2b_gap%0d got=%0d want=2", k,
                 (gaps.size() <= g0 + k) ? -1 : gaps[g0+k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (lens.size() < 4 || lens[lens.size()-4+k] != W) begin
        bad++; $display("FAIL b2b_len%0d got=%0d want=%0d", k,
                        (lens.size() < 4) ? -1 : lens[lens.size()-4+k], W);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    int f0;
    logic want_rdy;
    f0 = frames;
    for (int k = 0; k < 6; k++) begin
      want_rdy = (k < 5);
      total++;
      if (rdy !== want_rdy) begin
        bad++;
        $display("FAIL ovf_ready%0d got=%b want=%b", k, rdy, want_rdy);
      end
      sum = W'(8'h10 + k);
      vld = 1'b1;
      if (k < 5) exp_q.push_back(W'(8'h10 + k));
      tick();
    end
    vld = 1'b0;
    total++;
    if (ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_set got=%b want=1", ovf);
    end
    for (int i = 0; i < 100 && frames < f0 + 5; i++) tick();
    total++;
    if (frames != f0 + 5) begin
      bad++; $display("FAIL ovf_frames got=%0d want=5", frames - f0);
    end
    total++;
    if (ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=%b want=1", ovf);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clr got=%b want=0", ovf);
    end
    repeat (3) tick();
  endtask

  task automatic test_stall();
    int f0;
    f0 = frames;
    sum = 8'hF0;
    vld = 1'b1;
    exp_q.push_back(8'hF0);
    tick();
    vld = 1'b0;
    for (int i = 0; i < 10 && !sfr; i++) tick();
    total++;
    if (sfr !== 1'b1) begin
      bad++; $display("FAIL stall_start got=%b want=1", sfr);
    end
    repeat (3) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sfr !== 1'b1 || sdat !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b%b want=10", i, sfr, sdat);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (sdat !== 1'b1) begin
        bad++; $display("FAIL stall_bit%0d got=%b want=1", i + 4, sdat);
      end
    end
    for (int i = 0; i < 20 && frames < f0 + 1; i++) tick();
    total++;
    if (frames != f0 + 1 || lens[lens.size()-1] != 11) begin
      bad++;
      $display("FAIL stall_len got=%0d want=11", lens[lens.size()-1]);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int f0;
    int hi;
    f0 = frames;
    for (int k = 0; k < 3; k++) begin
      sum = W'(8'h3C + k);
      vld = 1'b1;
      exp_q.push_back(W'(8'h3C + k));
      tick();
    end
    vld = 1'b0;
    for (int i = 0; i < 10 && !sfr; i++) tick();
    repeat (4) tick();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    total++;
    if (sfr !== 1'b0 || sdat !== 1'b0) begin
      bad++; $display("FAIL rmid_out got=%b%b want=00", sfr, sdat);
    end
    total++;
    if (lvl !== '0 || rdy !== 1'b1) begin
      bad++; $display("FAIL rmid_fifo got=%0d/%b want=0/1", lvl, rdy);
    end
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sfr) hi++;
    end
    total++;
    if (hi != 0 || frames != f0) begin
      bad++; $display("FAIL rmid_quiet got=%0d want=0", hi);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sum_serializer.md
# sum_serializer

Downstream stage for the 8-bit adder macro in the user project area. Captures each `sum` the adder produces (qualified by a strobe) into a small FIFO, then shifts every captured word out LSB-first on a single serial pin with a frame marker. This lets one IO pair carry results off-chip instead of eight parallel `io_out` pins. Fully synchronous to the Wishbone clock.

## Interface

Parameters:
- `WIDTH`, 8: sum width in bits. Matches the adder.
- `DEPTH`, 4: FIFO entries. Must be a power of 2, ≥2.

Ports:
- `wb_clk_i`  in  1  single clock; all state changes on its rising edge.
- `wb_rst_i`  in  1  reset; synchronous, active-low (0 = reset).
- `vdd`  in  1  power pin; no logic function.
- `vss`  in  1  ground pin; no logic function.
- `sum_i`  in  WIDTH  adder result to capture.
- `sum_valid_i`  in  1  capture strobe; one word per cycle when high.
- `sum_ready_o`  out  1  FIFO not full.
- `ser_en_i`  in  1  shift enable. Low stalls the frame in progress.
- `clr_ovf_i`  in  1  clears `overflow_o`.
- `ser_data_o`  out  1  serial data, LSB first.
- `ser_frame_o`  out  1  high while data bits are on `ser_data_o`.
- `overflow_o`  out  1  sticky: a word was dropped because the FIFO was full.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation

- **Push.** A push occurs when `sum_valid_i` and `sum_ready_o` are both high; `sum_i` is written at the tail.
- **Dropped push.** If `sum_valid_i` is high while `sum_ready_o` is low, the word is dropped and `overflow_o` is set. This holds even if a pop happens in the same cycle.
- **`sum_ready_o`.** Equals `!full`, derived from the current `level_o`.
- **`overflow_o`.** Stays high until reset or `clr_ovf_i`. If `clr_ovf_i` and a new drop occur in the same cycle, the set wins.
- **`level_o`.** +1 on push, −1 on pop, unchanged when both occur. Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, LOAD, SHIFT, GAP.
  - IDLE: `level_o != 0` → LOAD.
  - LOAD: copy the head into the shift register, pop (read pointer +1), clear the bit counter → SHIFT.
  - SHIFT: `ser_frame_o = 1` and `ser_data_o = shreg[0]`.
    - If `ser_en_i`: shift right and increment the counter. When the counter reaches WIDTH−1 with `ser_en_i` high → GAP.
    - If `!ser_en_i`: hold the shift register, counter and outputs.
  - GAP: `ser_frame_o = 0` → LOAD if `level_o != 0`, else IDLE.
- **Outputs outside SHIFT:** `ser_data_o = 0` and `ser_frame_o = 0`.
- **Output timing:** `ser_data_o` and `ser_frame_o` are registered, i.e. decoded from the state and shift-register flops with no combinational path from inputs.
- **Stall independence:** `ser_en_i` has no effect in IDLE, LOAD or GAP. Pushes continue during stalls.
- **Reset values** (`wb_rst_i` = 0 at a clock edge):
  - state IDLE, FIFO emptied, `level_o = 0`, `sum_ready_o = 1`;
  - `ser_data_o = 0`, `ser_frame_o = 0`, `overflow_o = 0`.
  - Reset mid-frame aborts the frame: outputs are 0 in the cycle after that edge, and queued words are discarded.

## Timing

- **Push to first bit:**
  - Push sampled at edge e0 → IDLE→LOAD at e1 → LOAD→SHIFT at e2.
  - Bit 0 is valid and `ser_frame_o` high during the cycle after e2.
- **Frame length:** WIDTH cycles of `ser_frame_o` high when `ser_en_i` is held high. Each cycle with `ser_en_i` low adds one cycle.
- **Back-to-back frames:** 2 low cycles (GAP, LOAD) between frames, giving a period of WIDTH+2 = 10 cycles at default parameters.
- **Occupancy visibility:** `level_o` and `sum_ready_o` reflect a push or pop in the cycle after the edge that performs it.
- **Throughput:** sustained input rate above 1 word per 10 cycles eventually fills the FIFO and causes drops.

## Test plan

- **Single word.** After reset, push `0xA5` at e0. Required:
  - `ser_frame_o` high for exactly 8 cycles starting after e2;
  - `ser_data_o` sequence 1,0,1,0,0,1,0,1;
  - `level_o` returns to 0 after e2, and `overflow_o` stays 0.
- **Back-to-back.** Push `0x01, 0x80, 0xFF, 0x00` on consecutive cycles with `ser_en_i` = 1. Required:
  - four 8-cycle frames carrying 10000000, 00000001, 11111111, 00000000;
  - exactly 2 frame-low cycles between frames.
- **Overflow.** Push 6 words `0x10..0x15` on consecutive cycles. Required:
  - `sum_ready_o` = 0 during the 6th cycle; `0x15` is dropped and `overflow_o` = 1;
  - frames carry `0x10..0x14` only.
  - Then pulse `clr_ovf_i` → `overflow_o` = 0 the next cycle.
- **Stall.** Push `0xF0`, then drive `ser_en_i` = 0 for 3 cycles while bit 3 is shown. Required:
  - bit 3 (value 0) held for 4 cycles, frame high for 11 cycles;
  - bits 4..7 = 1 afterwards.
- **Reset mid-frame.** Push 3 words, then drive `wb_rst_i` low while bit 4 of the first frame is shown. Required:
  - in the next cycle `ser_frame_o` = 0, `ser_data_o` = 0, `level_o` = 0, `sum_ready_o` = 1;
  - after reset is released, no frame appears without new pushes.
